// File: rtl/shift_seq_unit_pkg.sv
// Shared datapath defines for the serial shift sequencer: mode/state encodings and default sizing.
// No logic of its own; imported by the sequencer and its amount mux.
package shift_seq_unit_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NSRC   = 4;

  typedef enum logic [1:0] {
    MODE_SLL = 2'd0,
    MODE_SRL = 2'd1,
    MODE_SRA = 2'd2,
    MODE_ROR = 2'd3
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/shift_seq_unit_amt_mux.sv
// Combinational amount select: low AMT_W bits of source word amt_sel, zero when amt_sel >= NSRC.
// Zero latency, no backpressure.
module shift_amt_mux
  import shift_seq_unit_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NSRC   = DEF_NSRC,
  parameter  int AMT_W  = $clog2(DATA_W),
  localparam int SEL_W  = $clog2(NSRC)
) (
  input  logic [SEL_W-1:0]       amt_sel,
  input  logic [NSRC*DATA_W-1:0] amt_src,
  output logic [AMT_W-1:0]       amt,
  output logic                   sel_bad
);

  logic [DATA_W-1:0] word;
  logic              hit;
  logic              unused_word_hi;

  // A one-hot compare loop keeps out-of-range selects from ever indexing past amt_src.
  always_comb begin
    word = '0;
    hit  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (amt_sel == SEL_W'(i)) begin
        word = amt_src[i*DATA_W +: DATA_W];
        hit  = 1'b1;
      end
    end
  end

  assign amt            = word[AMT_W-1:0];
  assign sel_bad        = ~hit;
  assign unused_word_hi = ^word[DATA_W-1:AMT_W];

endmodule

// File: rtl/shift_seq_unit.sv
// Bit-serial shifter: amount k takes k+1 cycles after the start edge (done pulses in the last).
// start is ignored while busy; operands are captured at the accepted start edge.
module shift_seq_unit
  import shift_seq_unit_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NSRC   = DEF_NSRC,
  localparam int AMT_W  = $clog2(DATA_W),
  localparam int SEL_W  = $clog2(NSRC)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [SEL_W-1:0]       amt_sel,
  input  logic [NSRC*DATA_W-1:0] amt_src,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   sel_err
);

  seq_state_e  state;
  shift_mode_e mode_q;
  logic [AMT_W-1:0] amt_q;
  logic [AMT_W-1:0] count;
  logic [AMT_W-1:0] amt;
  logic             sel_bad;

  shift_amt_mux #(
    .DATA_W (DATA_W),
    .NSRC   (NSRC),
    .AMT_W  (AMT_W)
  ) u_amt_mux (
    .amt_sel (amt_sel),
    .amt_src (amt_src),
    .amt     (amt),
    .sel_bad (sel_bad)
  );

  function automatic logic [DATA_W-1:0] shift_one(input shift_mode_e m,
                                                  input logic [DATA_W-1:0] d);
    case (m)
      MODE_SLL: shift_one = {d[DATA_W-2:0], 1'b0};
      MODE_SRL: shift_one = {1'b0, d[DATA_W-1:1]};
      MODE_SRA: shift_one = {d[DATA_W-1], d[DATA_W-1:1]};
      default:  shift_one = {d[0], d[DATA_W-1:1]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      data_out <= '0;
      count    <= '0;
      mode_q   <= MODE_SLL;
      amt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      sel_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            data_out <= data_in;
            mode_q   <= shift_mode_e'(mode);
            amt_q    <= amt;
            count    <= amt;
            sel_err  <= sel_bad;
            busy     <= 1'b1;
            if (amt != '0) begin
              state <= ST_SHIFT;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          data_out <= shift_one(mode_q, data_out);
          count    <= count - AMT_W'(1);
          // done is registered, so raise it on the same edge that enters DONE.
          if (count == AMT_W'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // amt_q keeps the captured amount for debug visibility; count is the live step counter.
  logic unused_amt_q;
  assign unused_amt_q = ^amt_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Directed bench for shift_seq_unit: default instance plus an NSRC=3 instance for out-of-range selects.
module tb_shift_seq_unit;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int NS3 = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, start3;
  logic [1:0]      mode;
  logic [1:0]      amt_sel;
  logic [NS*DW-1:0] amt_src;
  logic [DW-1:0]   data_in;
  logic [DW-1:0]   data_out, data_out3;
  logic            busy, done, sel_err;
  logic            busy3, done3, sel_err3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_seq_unit #(.DATA_W(DW), .NSRC(NS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .amt_sel(amt_sel),
    .amt_src(amt_src), .data_in(data_in), .data_out(data_out), .busy(busy),
    .done(done), .sel_err(sel_err)
  );

  shift_seq_unit #(.DATA_W(DW), .NSRC(NS3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .mode(mode), .amt_sel(amt_sel),
    .amt_src(amt_src[NS3*DW-1:0]), .data_in(data_in), .data_out(data_out3), .busy(busy3),
    .done(done3), .sel_err(sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    amt_src[i*DW +: DW] = v;
  endtask

  // Drives one accepted start edge; returns in cycle 1 after it.
  task automatic start_op(input logic [1:0] m, input logic [1:0] sel, input logic [31:0] d);
    mode    = m;
    amt_sel = sel;
    data_in = d;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // From cycle 1 after start, waits (bounded) for done on the default instance.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [1:0] m, input logic [1:0] sel,
                       input logic [31:0] d, input logic [31:0] exp, input int exp_lat);
    int cyc;
    start_op(m, sel, d);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_selerr"}, 32'(sel_err), 32'd0);
    wait_done(tag, cyc);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_data"}, data_out, exp);
    step();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, data_out, exp);
  endtask

  initial begin
    int cyc, busy_cnt, pulses, pulse_at;

    reset_n = 1'b0;
    start   = 1'b0;
    start3  = 1'b0;
    mode    = 2'd0;
    amt_sel = 2'd0;
    amt_src = '0;
    data_in = 32'hDEAD_BEEF;
    step();
    // reset has priority over start
    start = 1'b1;
    step();
    start = 1'b0;
    check("rst_data", data_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_selerr", 32'(sel_err), 32'd0);
    reset_n = 1'b1;
    step();

    // SLL 1 by 4: busy 5 cycles, done in cycle 5
    set_word(1, 32'h0000_0004);
    start_op(2'd0, 2'd1, 32'h0000_0001);
    busy_cnt = 0;
    cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      if (busy) busy_cnt++;
      if (done) cyc = c;
      if (c < 6) step();
    end
    check("sll4_busycnt", 32'(busy_cnt), 32'd5);
    check("sll4_donecyc", 32'(cyc), 32'd5);
    check("sll4_data", data_out, 32'h0000_0010);

    set_word(2, 32'd31);
    do_op("sra31", 2'd2, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32);
    do_op("srl31", 2'd1, 2'd2, 32'h8000_0000, 32'h0000_0001, 32);
    set_word(0, 32'd1);
    do_op("ror1", 2'd3, 2'd0, 32'h0000_0003, 32'h8000_0001, 2);
    set_word(3, 32'd0);
    do_op("amt0", 2'd0, 2'd3, 32'h1234_5678, 32'h1234_5678, 1);
    // only the low 5 bits of a source word count
    set_word(3, 32'hFFFF_FFE3);
    do_op("trunc", 2'd0, 2'd3, 32'h0000_0001, 32'h0000_0008, 4);
    set_word(0, 32'd3);
    do_op("sra_pos", 2'd2, 2'd0, 32'h4000_0000, 32'h0800_0000, 4);
    set_word(0, 32'd31);
    do_op("ror31", 2'd3, 2'd0, 32'h0000_0001, 32'h0000_0002, 32);

    // NSRC=3, select 3 is out of range: amount 0 with a sel_err pulse
    mode    = 2'd1;
    amt_sel = 2'd3;
    data_in = 32'hCAFE_0001;
    start3  = 1'b1;
    step();
    start3  = 1'b0;
    check("ns3_selerr", 32'(sel_err3), 32'd1);
    check("ns3_done", 32'(done3), 32'd1);
    check("ns3_data", data_out3, 32'hCAFE_0001);
    step();
    check("ns3_selerr_clr", 32'(sel_err3), 32'd0);
    check("ns3_done_clr", 32'(done3), 32'd0);
    check("ns3_idle", 32'(busy3), 32'd0);
    set_word(2, 32'd5);
    amt_sel = 2'd2;
    data_in = 32'h0000_0100;
    start3  = 1'b1;
    step();
    start3  = 1'b0;
    check("ns3_sel2_selerr", 32'(sel_err3), 32'd0);
    cyc = 1;
    while (!done3 && cyc < 100) begin
      step();
      cyc++;
    end
    check("ns3_sel2_lat", 32'(cyc), 32'd6);
    check("ns3_sel2_data", data_out3, 32'h0000_0008);
    step();

    // reset at the 2nd SHIFT edge of a 10-bit shift aborts; next start is accepted
    set_word(1, 32'd10);
    start_op(2'd0, 2'd1, 32'h0000_0001);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", data_out, 32'h0);
    check("abort_done", 32'(done), 32'd0);
    set_word(1, 32'd2);
    do_op("after_abort", 2'd0, 2'd1, 32'h0000_0003, 32'h0000_000C, 3);

    // start held high with inputs churning during an 8-bit SLL
    set_word(0, 32'd8);
    start_op(2'd0, 2'd0, 32'h0000_0001);
    start    = 1'b1;
    pulses   = 0;
    pulse_at = 0;
    for (int c = 1; c <= 9; c++) begin
      if (done) begin
        pulses++;
        pulse_at = c;
      end
      set_word(0, $urandom);
      mode    = 2'($urandom_range(3, 0));
      amt_sel = 2'($urandom_range(3, 0));
      data_in = $urandom;
      step();
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_pulse_at", 32'(pulse_at), 32'd9);
    check("hold_idle", 32'(busy), 32'd0);
    check("hold_data", data_out, 32'h0000_0100);
    set_word(0, 32'd2);
    mode    = 2'd0;
    amt_sel = 2'd0;
    data_in = 32'h0000_0005;
    step();
    start = 1'b0;
    check("reaccept_busy", 32'(busy), 32'd1);
    wait_done("reaccept", cyc);
    check("reaccept_lat", 32'(cyc), 32'd3);
    check("reaccept_data", data_out, 32'h0000_0014);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 Parameter DATA_W, default 32, data width; power of two, at least 8.
REQ-002 Parameter NSRC, default 4, number of shift-amount source words; at least 2.
REQ-003 Derived constants: AMT_W = clog2(DATA_W) (5 at default); SEL_W = clog2(NSRC) (2 at default).
REQ-004 Port clk  in  1  single clock, rising edge.
REQ-005 Port reset_n  in  1  synchronous active-low reset.
REQ-006 Port start  in  1  request a shift operation; sampled only in IDLE.
REQ-007 Port mode  in  2  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROR (rotate right).
REQ-008 Port amt_sel  in  SEL_W  selects the amount source word.
REQ-009 Port amt_src  in  NSRC*DATA_W  flattened source words; word i is bits [i*DATA_W +: DATA_W].
REQ-010 Port data_in  in  DATA_W  operand.
REQ-011 Port data_out  out  DATA_W  working/result register.
REQ-012 Port busy  out  1  high whenever the state is not IDLE.
REQ-013 Port done  out  1  single-cycle completion pulse.
REQ-014 Port sel_err  out  1  single-cycle pulse: amt_sel >= NSRC at an accepted start.

Function
REQ-015 The amount shall be bits [AMT_W-1:0] of source word amt_sel; amt_sel >= NSRC shall yield amount 0, never a latch or X.
REQ-016 The FSM shall have exactly three states: IDLE, SHIFT, DONE.
REQ-017 On a clock edge in IDLE with start=1, the block shall load data_out<=data_in, latch mode and amount into internal registers, and set count<=amount.
REQ-018 The same edge shall go to SHIFT if amount!=0, otherwise to DONE.
REQ-019 In SHIFT, each edge shall shift data_out by one bit per the latched mode and decrement count.
REQ-020 The shift rules: SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates the MSB; ROR moves the LSB to the MSB.
REQ-021 The edge on which count goes 1->0 shall move SHIFT->DONE.
REQ-022 With amount k, done shall be high in the cycle after the k-th shift edge; with k=0, in the cycle after the start edge.
REQ-023 DONE shall last exactly one cycle, done=1 during it, then go to IDLE.
REQ-024 start while busy shall be ignored; amt_sel, amt_src, mode and data_in changes while busy shall not affect the operation.
REQ-025 data_out shall hold the result from DONE until the next accepted start.
REQ-026 sel_err shall be high for one cycle, the cycle after the accepted start edge, and the operation shall complete normally with amount 0.
REQ-027 The maximum amount is DATA_W-1; no modulo beyond the AMT_W truncation is applied.

Reset
REQ-028 With reset_n=0 at an edge: state<=IDLE, data_out<=0, count<=0, latched mode/amount<=0, done=0, sel_err=0, busy=0.
REQ-029 Reset during SHIFT or DONE shall abort without a done pulse; reset shall take priority over start.

Structure
REQ-030 Mode encodings and state encodings shall live in the shared datapath defines include, alongside the existing mux select constants.
REQ-031 Amount selection shall be a separate combinational sub-module, shift_amt_mux, parametrised by DATA_W, NSRC and AMT_W, and instantiated once.
REQ-032 The shifter step shall be one bit per cycle; no barrel shifter.

Verification
REQ-033 Scenario: SLL, data_in=0x0000_0001, amt_src word1=0x0000_0004, amt_sel=1 -> busy for 5 cycles; done in cycle 5 after start; data_out=0x0000_0010.
REQ-034 Scenario: SRA, data_in=0x8000_0000, amount 31 -> data_out=0xFFFF_FFFF. Then SRL on the same value with amount 31 -> data_out=0x0000_0001.
REQ-035 Scenario: ROR, data_in=0x0000_0003, amount 1 -> data_out=0x8000_0001. Then amount 0 -> done one cycle after start, data_out=data_in.
REQ-036 Scenario: NSRC=3, amt_sel=3 -> sel_err pulse and done one cycle after start; data_out unchanged.
REQ-037 Scenario: reset_n low at the 2nd SHIFT edge of a 10-bit shift -> next cycle IDLE, data_out=0, no done pulse. Then a start at the next edge is accepted normally.
REQ-038 Scenario: start held high and amt_src toggled during an 8-bit SLL -> exactly one done pulse, amount 8 used. A new operation is accepted on the first IDLE cycle after DONE.
